// File: rtl/pc_sequencer_if.sv
// Return-stack port bundle between the PC sequencer and the 5-entry PC/flags stack.
interface pc_sequencer_if #(
    parameter int unsigned PC_W   = 9,
    parameter int unsigned FLAG_W = 4
) ();

    logic              push_en;
    logic              pop_en;
    logic [PC_W-1:0]   stk_in_pc;
    logic [FLAG_W-1:0] stk_in_flags;
    logic [PC_W-1:0]   stk_out_pc;     // stored PC + 1
    logic [FLAG_W-1:0] stk_out_flags;

    // Sequencer side: issues strobes and operands, reads top of stack.
    modport master (
        output push_en, pop_en, stk_in_pc, stk_in_flags,
        input  stk_out_pc, stk_out_flags
    );

    // Stack side.
    modport slave (
        input  push_en, pop_en, stk_in_pc, stk_in_flags,
        output stk_out_pc, stk_out_flags
    );

endinterface

// File: rtl/pc_sequencer.sv
// Program counter / control-flow stage: PC and flags registers, control-op decode,
// two-cycle interrupt entry, and return-stack strobes with occupancy tracking.
module pc_sequencer #(
    parameter int unsigned     PC_W        = 9,
    parameter int unsigned     FLAG_W      = 4,
    parameter int unsigned     STACK_DEPTH = 5,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [PC_W-1:0] IRQ_VECTOR  = PC_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [PC_W-1:0]   target,
    input  logic [1:0]        cond_sel,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flags_we,
    input  logic              irq,
    pc_sequencer_if.master    stk,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_valid,
    output logic [FLAG_W-1:0] flags,
    output logic              ie,
    output logic [2:0]        depth,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [2:0] {
        OpNext  = 3'b000,
        OpJmp   = 3'b001,
        OpJcond = 3'b010,
        OpCall  = 3'b011,
        OpRet   = 3'b100,
        OpHalt  = 3'b101,
        OpReti  = 3'b110,
        OpRsvd  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StRun,
        StIrqEntry,
        StHalted
    } state_e;

    localparam logic [2:0] DepthMax = 3'(STACK_DEPTH);

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [FLAG_W-1:0] flags_q;
    logic              ie_q;
    logic [2:0]        depth_q;
    logic              overflow_q;
    logic              underflow_q;

    op_e             op_dec;
    logic [PC_W-1:0] pc_inc;
    logic            irq_take;
    logic            exec;
    logic            do_call;
    logic            do_ret;
    logic            push;
    logic            pop;

    assign op_dec = op_e'(op);
    assign pc_inc = pc_q + PC_W'(1);

    // Decode this cycle's action; an accepted interrupt discards the op at pc.
    always_comb begin
        irq_take = rst_n && irq && ie_q && !stall && (state_q != StIrqEntry);
        exec     = rst_n && !stall && (state_q == StRun) && !irq_take;
        do_call  = exec && (op_dec == OpCall);
        do_ret   = exec && ((op_dec == OpRet) || (op_dec == OpReti));
        push     = irq_take || do_call;
        pop      = do_ret && (depth_q != 3'd0);
    end

    // Stack operands: interrupt pushes pc-1 so the stack's +1 resumes at the discarded op.
    always_comb begin
        stk.push_en      = push;
        stk.pop_en       = pop;
        stk.stk_in_pc    = irq_take ? (pc_q - PC_W'(1)) : pc_q;
        stk.stk_in_flags = flags_q;
    end

    // Sequencer state: PC, flags, interrupt enable, depth and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            flags_q     <= '0;
            ie_q        <= 1'b1;
            depth_q     <= 3'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!stall) begin
            if (flags_we) begin
                flags_q <= alu_flags;
            end

            // Stack drops its oldest entry on overflow, so depth saturates.
            if (push) begin
                if (depth_q == DepthMax) begin
                    overflow_q <= 1'b1;
                end else begin
                    depth_q <= depth_q + 3'd1;
                end
            end else if (pop) begin
                depth_q <= depth_q - 3'd1;
            end

            if (irq_take) begin
                ie_q    <= 1'b0;
                state_q <= StIrqEntry;
            end else begin
                unique case (state_q)
                    StIrqEntry: begin
                        pc_q    <= IRQ_VECTOR;
                        state_q <= StRun;
                    end
                    StHalted: ;
                    StRun: begin
                        unique case (op_dec)
                            OpJmp:   pc_q <= target;
                            OpJcond: pc_q <= flags_q[cond_sel] ? target : pc_inc;
                            OpCall:  pc_q <= target;
                            OpRet, OpReti: begin
                                if (pop) begin
                                    pc_q <= stk.stk_out_pc;
                                    // Later assignment overrides the flags_we load above.
                                    if (op_dec == OpReti) begin
                                        flags_q <= stk.stk_out_flags;
                                        ie_q    <= 1'b1;
                                    end
                                end else begin
                                    pc_q        <= pc_inc;
                                    underflow_q <= 1'b1;
                                end
                            end
                            OpHalt: begin
                                pc_q    <= pc_inc;
                                state_q <= StHalted;
                            end
                            default: pc_q <= pc_inc;
                        endcase
                    end
                    default: state_q <= StRun;
                endcase
            end
        end
    end

    assign pc          = pc_q;
    assign flags       = flags_q;
    assign ie          = ie_q;
    assign depth       = depth_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign fetch_valid = rst_n && (state_q == StRun);

endmodule
